ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B (NeoPixel) single-wire receiver.
// Synchronises the serial line and classifies each high pulse by its width as a 0 or a 1.
// Bits are assembled MSB-first into GRB pixels, and each pixel is strobed out with its LED index.
// A long low gap ends the frame and reports how many pixels were received.
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50_000_000
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        di_i,
  output logic                        pixel_valid_o,
  output logic [$clog2(NUM_LEDS)-1:0] address_o,
  output logic [7:0]                  red_o,
  output logic [7:0]                  green_o,
  output logic [7:0]                  blue_o,
  output logic                        frame_done_o,
  output logic [$clog2(NUM_LEDS):0]   led_count_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o,
  output logic                        busy_o
);

  localparam int IDX_W         = $clog2(NUM_LEDS);
  localparam int CNT_W         = IDX_W + 1;
  localparam int CYCLE_COUNT   = (SYSTEM_CLOCK / 800_000) - 3;
  localparam int THRESH_CYCLES = (CYCLE_COUNT * 48) / 100;
  localparam int MAX_HIGH      = 2 * CYCLE_COUNT;
  localparam int RESET_DETECT  = SYSTEM_CLOCK / 20_000;
  localparam int HC_W          = $clog2(MAX_HIGH + 1);
  localparam int LC_W          = $clog2(RESET_DETECT + 1);

  localparam logic [HC_W-1:0]  THRESH_C   = HC_W'(THRESH_CYCLES);
  localparam logic [HC_W-1:0]  MAX_HIGH_C = HC_W'(MAX_HIGH);
  localparam logic [LC_W-1:0]  RESET_C    = LC_W'(RESET_DETECT);
  localparam logic [CNT_W-1:0] NUM_LEDS_C = CNT_W'(NUM_LEDS);

  localparam logic [1:0] ERR_LONG_HIGH = 2'd1;
  localparam logic [1:0] ERR_PARTIAL   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  logic sync1_q, sync2_q, hist_q;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   high_cnt_q, high_cnt_d;
  logic [LC_W-1:0]   low_cnt_q, low_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [22:0]       shift_q, shift_d;
  logic [CNT_W-1:0]  pix_idx_q, pix_idx_d;
  logic              ovf_q, ovf_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]  address_q, address_d;
  logic [7:0]        red_q, red_d;
  logic [7:0]        green_q, green_d;
  logic [7:0]        blue_q, blue_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  led_count_q, led_count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;

  logic              rise, fall;
  logic              bit_val;
  logic [23:0]       new_word;
  logic [HC_W-1:0]   high_inc;
  logic [LC_W-1:0]   low_inc;
  logic              err_long, err_partial, err_overflow;

  // Two-flop synchroniser for the asynchronous line, plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= di_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~hist_q;
  assign fall     = ~sync2_q & hist_q;
  assign bit_val  = (high_cnt_q >= THRESH_C);
  assign new_word = {shift_q, bit_val};
  assign high_inc = (high_cnt_q >= MAX_HIGH_C) ? high_cnt_q : high_cnt_q + HC_W'(1);
  assign low_inc  = (low_cnt_q >= RESET_C) ? low_cnt_q : low_cnt_q + LC_W'(1);

  // Next-state decode: pulse timing, bit assembly, pixel/frame strobes and error prioritisation
  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pix_idx_d     = pix_idx_q;
    ovf_d         = ovf_q;
    pixel_valid_d = 1'b0;
    address_d     = address_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    frame_done_d  = 1'b0;
    led_count_d   = led_count_q;
    err_d         = 1'b0;
    err_code_d    = 2'd0;
    err_long      = 1'b0;
    err_partial   = 1'b0;
    err_overflow  = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        if (sync2_q) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= RESET_C) state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = HC_W'(1);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          shift_d   = new_word[22:0];
          low_cnt_d = LC_W'(1);
          state_d   = ST_LOW;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (pix_idx_q < NUM_LEDS_C) begin
              pixel_valid_d = 1'b1;
              address_d     = pix_idx_q[IDX_W-1:0];
              green_d       = new_word[23:16];
              red_d         = new_word[15:8];
              blue_d        = new_word[7:0];
              pix_idx_d     = pix_idx_q + CNT_W'(1);
            end else if (!ovf_q) begin
              err_overflow = 1'b1;
              ovf_d        = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          high_cnt_d = high_inc;
          if (high_inc >= MAX_HIGH_C) begin
            // A stuck-high line means we have lost framing: drop everything and resynchronise
            err_long  = 1'b1;
            state_d   = ST_SYNC;
            low_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            pix_idx_d = '0;
            ovf_d     = 1'b0;
          end
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = HC_W'(1);
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= RESET_C) begin
            // The index never exceeds NUM_LEDS, so it is already min(index, NUM_LEDS)
            frame_done_d = 1'b1;
            led_count_d  = pix_idx_q;
            err_partial  = (bit_cnt_q != 5'd0);
            bit_cnt_d    = '0;
            shift_d      = '0;
            pix_idx_d    = '0;
            ovf_d        = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_SYNC;
    endcase

    if (err_long) begin
      err_d      = 1'b1;
      err_code_d = ERR_LONG_HIGH;
    end else if (err_partial) begin
      err_d      = 1'b1;
      err_code_d = ERR_PARTIAL;
    end else if (err_overflow) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERFLOW;
    end

    busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
  end

  // State, counters and registered outputs; reset lands in SYNC so decoding never starts mid-frame
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pix_idx_q     <= '0;
      ovf_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      address_q     <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_done_q  <= 1'b0;
      led_count_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pix_idx_q     <= pix_idx_d;
      ovf_q         <= ovf_d;
      pixel_valid_q <= pixel_valid_d;
      address_q     <= address_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_done_q  <= frame_done_d;
      led_count_q   <= led_count_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign pixel_valid_o = pixel_valid_q;
  assign address_o     = address_q;
  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign frame_done_o  = frame_done_q;
  assign led_count_o   = led_count_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for the WS2812 receiver.
// Drives hand-built pulse trains on di_i and logs the strobes it sees.
// Every expectation is a hand-computed constant.
module tb_ws2812_rx;

   localparam int NUM_LEDS = 8;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       di_i;
   logic       pixel_valid_o;
   logic [2:0] address_o;
   logic [7:0] red_o;
   logic [7:0] green_o;
   logic [7:0] blue_o;
   logic       frame_done_o;
   logic [3:0] led_count_o;
   logic       err_o;
   logic [1:0] err_code_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } pixT;

   pixT        pixLog[$];
   logic [1:0] errLog[$];
   int         errPixCount;
   int         fdCount;
   logic [3:0] fdLedCount;
   logic       fdWithErr2;

   ws2812_rx #(
      .NUM_LEDS(NUM_LEDS),
      .SYSTEM_CLOCK(50_000_000)
   ) dut (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .di_i(di_i),
      .pixel_valid_o(pixel_valid_o),
      .address_o(address_o),
      .red_o(red_o),
      .green_o(green_o),
      .blue_o(blue_o),
      .frame_done_o(frame_done_o),
      .led_count_o(led_count_o),
      .err_o(err_o),
      .err_code_o(err_code_o),
      .busy_o(busy_o)
   );

   // 50 MHz clock
   always #10 clk_i = ~clk_i;

   // Capture one-cycle strobes away from the active edge so the main sequence can inspect them later
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (err_o) begin
            errLog.push_back(err_code_o);
            errPixCount = pixLog.size();
            if (frame_done_o && err_code_o == 2'd2) fdWithErr2 = 1'b1;
         end
         if (pixel_valid_o) pixLog.push_back({address_o, green_o, red_o, blue_o});
         if (frame_done_o) begin
            fdCount++;
            fdLedCount = led_count_o;
         end
      end
   end

   // Hard time limit so the run always ends on its own
   initial begin
      repeat (90000) @(posedge clk_i);
      errors++;
      $display("[TB] FAIL watchdog: observed no end of sequence, expected finish within 90000 cycles");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic level, input int cycles);
      di_i = level;
      repeat (cycles) @(negedge clk_i);
   endtask

   task automatic sendBit(input logic b);
      if (b) begin
         applyStimulus(1'b1, 37);
         applyStimulus(1'b0, 22);
      end else begin
         applyStimulus(1'b1, 18);
         applyStimulus(1'b0, 41);
      end
   endtask

   task automatic sendPixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
      logic [23:0] w;
      w = {g, r, b};
      for (int i = 23; i >= 0; i--) sendBit(w[i]);
   endtask

   task automatic clearLogs();
      pixLog.delete();
      errLog.delete();
      errPixCount = -1;
      fdCount     = 0;
      fdLedCount  = 4'd0;
      fdWithErr2  = 1'b0;
   endtask

   function automatic logic [63:0] pixAt(input int idx);
      if (idx < pixLog.size()) return 64'(pixLog[idx]);
      return 64'hDEAD_BEEF_DEAD;
   endfunction

   function automatic logic [63:0] errAt(input int idx);
      if (idx < errLog.size()) return 64'(errLog[idx]);
      return 64'hDEAD_BEEF_DEAD;
   endfunction

   // Directed sequence: reset, sync, decode, multi-pixel, thresholds, overflow, faults, mid-frame reset
   initial begin
      logic [23:0] w;
      logic [7:0]  v;

      clearLogs();
      reset_ni = 1'b0;
      di_i     = 1'b0;
      repeat (5) @(negedge clk_i);
      checkOutput("rst_outputs", 64'({pixel_valid_o, address_o, red_o, green_o, blue_o,
                                     frame_done_o, err_o, err_code_o}), 64'd0);
      checkOutput("rst_led_count", 64'(led_count_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);

      reset_ni = 1'b1;
      applyStimulus(1'b0, 2600);
      checkOutput("sync_not_busy", 64'(busy_o), 64'd0);

      $display("[TB] single pixel decode with latency");
      clearLogs();
      w = 24'hA53CFF;
      for (int i = 23; i >= 1; i--) sendBit(w[i]);
      applyStimulus(1'b1, 37);
      di_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      checkOutput("lat_edge2", 64'(pixel_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      checkOutput("lat_edge3", 64'(pixel_valid_o), 64'd1);
      checkOutput("lat_data", 64'({address_o, green_o, red_o, blue_o}), 64'({3'd0, 8'hA5, 8'h3C, 8'hFF}));
      checkOutput("busy_in_frame", 64'(busy_o), 64'd1);
      @(negedge clk_i);
      applyStimulus(1'b0, 3000);
      checkOutput("p1_count", 64'(pixLog.size()), 64'd1);
      checkOutput("p1_pix0", pixAt(0), 64'({3'd0, 8'hA5, 8'h3C, 8'hFF}));
      checkOutput("p1_frame_done", 64'(fdCount), 64'd1);
      checkOutput("p1_led_count", 64'(led_count_o), 64'd1);
      checkOutput("p1_no_err", 64'(errLog.size()), 64'd0);
      checkOutput("p1_hold_red", 64'(red_o), 64'h3C);

      $display("[TB] eight pixel frame");
      clearLogs();
      for (int i = 0; i < 8; i++) begin
         v = 8'(i * 17);
         sendPixel(v, v, v);
      end
      applyStimulus(1'b0, 2700);
      checkOutput("p8_count", 64'(pixLog.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         v = 8'(i * 17);
         checkOutput($sformatf("p8_pix%0d", i), pixAt(i), 64'({3'(i), v, v, v}));
      end
      checkOutput("p8_led_count", 64'(led_count_o), 64'd8);
      checkOutput("p8_frame_done", 64'(fdCount), 64'd1);
      checkOutput("p8_no_err", 64'(errLog.size()), 64'd0);

      $display("[TB] threshold widths 27 and 28");
      clearLogs();
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'b1, (i < 12) ? 27 : 28);
         applyStimulus(1'b0, 40);
      end
      applyStimulus(1'b0, 2700);
      checkOutput("thr_pix0", pixAt(0), 64'({3'd0, 8'h00, 8'h0F, 8'hFF}));
      checkOutput("thr_led_count", 64'(fdLedCount), 64'd1);

      $display("[TB] overflow with ten pixels");
      clearLogs();
      for (int i = 0; i < 10; i++) begin
         v = 8'(i * 17);
         sendPixel(v, v, v);
      end
      applyStimulus(1'b0, 2700);
      checkOutput("ovf_count", 64'(pixLog.size()), 64'd8);
      checkOutput("ovf_pix7", pixAt(7), 64'({3'd7, 8'd119, 8'd119, 8'd119}));
      checkOutput("ovf_err_count", 64'(errLog.size()), 64'd1);
      checkOutput("ovf_err_code", errAt(0), 64'd3);
      checkOutput("ovf_err_on_pix9", 64'(errPixCount), 64'd8);
      checkOutput("ovf_led_count", 64'(led_count_o), 64'd8);
      checkOutput("ovf_frame_done", 64'(fdCount), 64'd1);

      $display("[TB] stuck-high pulse");
      clearLogs();
      applyStimulus(1'b1, 118);
      applyStimulus(1'b0, 5);
      checkOutput("long_err_count", 64'(errLog.size()), 64'd1);
      checkOutput("long_err_code", errAt(0), 64'd1);
      checkOutput("long_not_busy", 64'(busy_o), 64'd0);
      applyStimulus(1'b0, 1000);
      sendPixel(8'h11, 8'h22, 8'h33);
      applyStimulus(1'b0, 2000);
      checkOutput("sync_no_decode", 64'(pixLog.size()), 64'd0);
      checkOutput("sync_no_frame", 64'(fdCount), 64'd0);
      checkOutput("sync_still_idle", 64'(busy_o), 64'd0);
      applyStimulus(1'b0, 600);

      $display("[TB] partial pixel at frame end");
      clearLogs();
      sendPixel(8'h81, 8'h42, 8'h24);
      for (int i = 0; i < 6; i++) sendBit((i % 2) == 0);
      applyStimulus(1'b0, 2700);
      checkOutput("part_count", 64'(pixLog.size()), 64'd1);
      checkOutput("part_pix0", pixAt(0), 64'({3'd0, 8'h81, 8'h42, 8'h24}));
      checkOutput("part_err_count", 64'(errLog.size()), 64'd1);
      checkOutput("part_err_code", errAt(0), 64'd2);
      checkOutput("part_err_with_done", 64'(fdWithErr2), 64'd1);
      checkOutput("part_led_count", 64'(led_count_o), 64'd1);

      $display("[TB] reset in the middle of bit 10");
      w = 24'hC35A96;
      for (int i = 23; i >= 15; i--) sendBit(w[i]);
      applyStimulus(1'b1, 10);
      checkOutput("mid_busy", 64'(busy_o), 64'd1);
      #3;
      reset_ni = 1'b0;
      #1;
      checkOutput("mid_rst_outputs", 64'({pixel_valid_o, address_o, red_o, green_o, blue_o,
                                         frame_done_o, err_o, err_code_o, busy_o}), 64'd0);
      checkOutput("mid_rst_led_count", 64'(led_count_o), 64'd0);
      di_i = 1'b0;
      repeat (3) @(negedge clk_i);
      reset_ni = 1'b1;
      applyStimulus(1'b0, 2600);
      clearLogs();
      sendPixel(8'hC3, 8'h5A, 8'h96);
      sendPixel(8'h12, 8'h34, 8'h56);
      applyStimulus(1'b0, 2700);
      checkOutput("post_count", 64'(pixLog.size()), 64'd2);
      checkOutput("post_pix0", pixAt(0), 64'({3'd0, 8'hC3, 8'h5A, 8'h96}));
      checkOutput("post_pix1", pixAt(1), 64'({3'd1, 8'h12, 8'h34, 8'h56}));
      checkOutput("post_led_count", 64'(led_count_o), 64'd2);
      checkOutput("post_no_err", 64'(errLog.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
